// File: rtl/pipeline_control_unit_if.sv
// Pipeline-to-control-unit bundle: stage request lines and interrupt inputs,
// plus the stall, PC-select and injected-instruction outputs.
interface pipeline_control_unit_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int INST_WIDTH = 32,
    parameter int NUM_IRQ    = 4
);
    logic                             return_req;
    logic                             halt;
    logic                             fetch_stl_req;
    logic                             dec_stl_req;
    logic [NUM_IRQ-1:0]               irq;
    logic                             irq_enable;
    logic [NUM_IRQ*ADDR_WIDTH-1:0]    irq_vector_table;
    logic [NUM_IRQ-1:0]               irq_ack;
    logic                             stall_fetch;
    logic                             stall_decode;
    logic [2:0]                       prog_cntr_load_sel;
    logic                             inst_word_sel;
    logic [INST_WIDTH-1:0]            new_inst_word;
    logic [ADDR_WIDTH-1:0]            prog_cntr_int_addr;
    logic                             in_isr;
    logic [2:0]                       control_state;

    modport master (
        output return_req, halt, fetch_stl_req, dec_stl_req, irq, irq_enable, irq_vector_table,
        input  irq_ack, stall_fetch, stall_decode, prog_cntr_load_sel, inst_word_sel,
               new_inst_word, prog_cntr_int_addr, in_isr, control_state
    );

    modport slave (
        input  return_req, halt, fetch_stl_req, dec_stl_req, irq, irq_enable, irq_vector_table,
        output irq_ack, stall_fetch, stall_decode, prog_cntr_load_sel, inst_word_sel,
               new_inst_word, prog_cntr_int_addr, in_isr, control_state
    );
endinterface

// File: rtl/pipeline_control_unit.sv
// Pipeline hazard/control FSM: halt, held stalls, prioritised non-nesting
// interrupt injection and a fixed-length return drain; Moore outputs.
module pipeline_control_unit #(
    parameter int ADDR_WIDTH = 14,
    parameter int INST_WIDTH = 32,
    parameter int NUM_IRQ    = 4,
    parameter int RET_DRAIN  = 3,
    parameter logic [INST_WIDTH-ADDR_WIDTH-1:0] INT_OPCODE = 18'h00042
) (
    input  logic                   clock,
    input  logic                   reset,
    pipeline_control_unit_if.slave bus
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int CNT_W = (RET_DRAIN > 1) ? $clog2(RET_DRAIN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RET_DRAIN - 1);

    typedef enum logic [2:0] {
        S_NORMAL = 3'd0,
        S_HALT   = 3'd1,
        S_INT    = 3'd2,
        S_STL_F  = 3'd3,
        S_STL_D  = 3'd4,
        S_RET    = 3'd5,
        S_UNUSED = 3'd6,
        S_RET_F  = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_IRQ-1:0]      pending_q, pending_d;
    logic [NUM_IRQ-1:0]      irq_prev_q;
    logic                    in_isr_q, in_isr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        line_q, line_d;
    logic [ADDR_WIDTH-1:0]   vec_q, vec_d;
    logic                    take_s;
    logic [IDX_W-1:0]        sel_s;
    logic [ADDR_WIDTH-1:0]   vec_sel_s;
    logic [NUM_IRQ-1:0]      ack_s;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Interrupt arbitration and pending-latch update (a new edge beats the ack)
    always_comb begin
        take_s    = bus.irq_enable & ~in_isr_q & (|pending_q);
        sel_s     = lowest_idx(pending_q);
        vec_sel_s = bus.irq_vector_table[int'(sel_s) * ADDR_WIDTH +: ADDR_WIDTH];
        ack_s     = (state_q == S_INT) ? (NUM_IRQ'(1) << line_q) : '0;
        pending_d = (pending_q & ~ack_s) | (bus.irq & ~irq_prev_q);
    end

    // Next-state, drain counter, ISR flag and vector capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_isr_d = in_isr_q;
        case (state_q)
            S_NORMAL: begin
                if (bus.return_req) begin
                    state_d = (RET_DRAIN == 1) ? S_RET_F : S_RET;
                    cnt_d   = '0;
                end else if (bus.halt) begin
                    state_d = S_HALT;
                end else if (bus.fetch_stl_req) begin
                    state_d = S_STL_F;
                end else if (bus.dec_stl_req) begin
                    state_d = S_STL_D;
                end else if (take_s) begin
                    state_d = S_INT;
                end else begin
                    state_d = S_NORMAL;
                end
            end
            S_HALT:  state_d = take_s ? S_INT : S_HALT;
            S_INT: begin
                state_d  = S_NORMAL;
                in_isr_d = 1'b1;
            end
            S_STL_F: state_d = bus.fetch_stl_req ? S_STL_F : (take_s ? S_INT : S_NORMAL);
            S_STL_D: state_d = bus.dec_stl_req ? S_STL_D : (take_s ? S_INT : S_NORMAL);
            S_RET: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_LAST - CNT_W'(1)) ? S_RET_F : S_RET;
            end
            S_RET_F: begin
                state_d  = S_NORMAL;
                cnt_d    = '0;
                in_isr_d = 1'b0;
            end
            default: state_d = S_NORMAL;
        endcase
        if (state_d == S_INT) begin
            line_d = sel_s;
            vec_d  = vec_sel_s;
        end else begin
            line_d = line_q;
            vec_d  = vec_q;
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_NORMAL;
            pending_q  <= '0;
            irq_prev_q <= '0;
            in_isr_q   <= 1'b0;
            cnt_q      <= '0;
            line_q     <= '0;
            vec_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            irq_prev_q <= bus.irq;
            in_isr_q   <= in_isr_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            vec_q      <= vec_d;
        end
    end

    // Moore output decode; the unused encoding falls through to NORMAL values
    always_comb begin
        bus.stall_fetch        = 1'b0;
        bus.stall_decode       = 1'b0;
        bus.prog_cntr_load_sel = 3'b001;
        bus.inst_word_sel      = 1'b0;
        bus.new_inst_word      = '0;
        bus.prog_cntr_int_addr = '0;
        bus.control_state      = (state_q == S_UNUSED) ? 3'd0 : state_q;
        case (state_q)
            S_HALT, S_STL_F, S_RET: begin
                bus.stall_fetch   = 1'b1;
                bus.inst_word_sel = 1'b1;
            end
            S_STL_D: begin
                bus.stall_fetch   = 1'b1;
                bus.stall_decode  = 1'b1;
                bus.inst_word_sel = 1'b1;
            end
            S_INT: begin
                bus.prog_cntr_load_sel = 3'b010;
                bus.inst_word_sel      = 1'b1;
                bus.new_inst_word      = {vec_q, INT_OPCODE};
                bus.prog_cntr_int_addr = vec_q;
            end
            S_RET_F: begin
                bus.stall_fetch        = 1'b1;
                bus.inst_word_sel      = 1'b1;
                bus.prog_cntr_load_sel = 3'b100;
            end
            default: bus.stall_fetch = 1'b0;
        endcase
    end

    assign bus.irq_ack = ack_s;
    assign bus.in_isr  = in_isr_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed and randomized bench for pipeline_control_unit against a
// mode/count behavioural model of the control sequencing.
module tb_pipeline_control_unit;
    localparam int AW = 14;
    localparam int IW = 32;
    localparam int NI = 4;
    localparam int RD = 3;
    localparam logic [17:0] OPC = 18'h00042;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    pipeline_control_unit_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .NUM_IRQ(NI)) bus ();

    pipeline_control_unit #(
        .ADDR_WIDTH(AW), .INST_WIDTH(IW), .NUM_IRQ(NI), .RET_DRAIN(RD), .INT_OPCODE(OPC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Model: mode 0 normal, 1 halt, 2 int, 3 fetch stall, 4 decode stall, 5 return drain
    int          m_mode, n_mode;
    int          m_cnt, n_cnt;
    logic [3:0]  m_pend, n_pend, m_prev, n_prev;
    logic        m_isr, n_isr;
    int          m_line, n_line;
    logic [13:0] m_vec, n_vec_m;
    bit          m_valid, n_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic sf, sd, iws;
        logic [2:0] sel, cs;
        logic [31:0] niw;
        logic [13:0] addr;
        logic [3:0] ack;
        sf = 1'b0; sd = 1'b0; iws = 1'b0; sel = 3'b001; cs = 3'd0;
        niw = 32'h0; addr = 14'h0; ack = 4'h0;
        case (m_mode)
            1: begin sf = 1'b1; iws = 1'b1; cs = 3'd1; end
            2: begin
                sel = 3'b010; iws = 1'b1; niw = {m_vec, OPC}; addr = m_vec;
                ack = 4'b0001 << m_line; cs = 3'd2;
            end
            3: begin sf = 1'b1; iws = 1'b1; cs = 3'd3; end
            4: begin sf = 1'b1; sd = 1'b1; iws = 1'b1; cs = 3'd4; end
            5: begin
                sf = 1'b1; iws = 1'b1;
                if (m_cnt == RD - 1) begin cs = 3'd7; sel = 3'b100; end
                else cs = 3'd5;
            end
            default: cs = 3'd0;
        endcase
        chk("control_state", 64'(bus.control_state), 64'(cs));
        chk("stall_fetch", 64'(bus.stall_fetch), 64'(sf));
        chk("stall_decode", 64'(bus.stall_decode), 64'(sd));
        chk("load_sel", 64'(bus.prog_cntr_load_sel), 64'(sel));
        chk("inst_word_sel", 64'(bus.inst_word_sel), 64'(iws));
        chk("new_inst_word", 64'(bus.new_inst_word), 64'(niw));
        chk("int_addr", 64'(bus.prog_cntr_int_addr), 64'(addr));
        chk("irq_ack", 64'(bus.irq_ack), 64'(ack));
        chk("in_isr", 64'(bus.in_isr), 64'(m_isr));
    endtask

    task automatic model_step();
        logic take;
        int low;
        logic [3:0] ack;
        n_valid = m_valid; n_mode = m_mode; n_cnt = m_cnt; n_isr = m_isr;
        n_line = m_line; n_vec_m = m_vec; n_pend = m_pend; n_prev = m_prev;
        if (reset) begin
            n_valid = 1'b1; n_mode = 0; n_cnt = 0; n_isr = 1'b0;
            n_line = 0; n_vec_m = 14'h0; n_pend = 4'h0; n_prev = 4'h0;
        end else begin
            take = bus.irq_enable && !m_isr && (m_pend != 4'h0);
            low = 0;
            for (int i = NI - 1; i >= 0; i--) if (m_pend[i]) low = i;
            ack = (m_mode == 2) ? (4'b0001 << m_line) : 4'h0;
            n_pend = (m_pend & ~ack) | (bus.irq & ~m_prev);
            n_prev = bus.irq;
            case (m_mode)
                0: begin
                    if (bus.return_req) begin n_mode = 5; n_cnt = 0; end
                    else if (bus.halt) n_mode = 1;
                    else if (bus.fetch_stl_req) n_mode = 3;
                    else if (bus.dec_stl_req) n_mode = 4;
                    else if (take) n_mode = 2;
                end
                1: if (take) n_mode = 2;
                2: begin n_mode = 0; n_isr = 1'b1; end
                3: if (!bus.fetch_stl_req) n_mode = take ? 2 : 0;
                4: if (!bus.dec_stl_req) n_mode = take ? 2 : 0;
                5: begin
                    if (m_cnt == RD - 1) begin n_mode = 0; n_cnt = 0; n_isr = 1'b0; end
                    else n_cnt = m_cnt + 1;
                end
                default: n_mode = 0;
            endcase
            if (n_mode == 2 && m_mode != 2) begin
                n_line = low;
                n_vec_m = bus.irq_vector_table[low*AW +: AW];
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        if (m_valid) check_all();
        model_step();
        @(posedge clock);
        m_valid = n_valid; m_mode = n_mode; m_cnt = n_cnt; m_isr = n_isr;
        m_line = n_line; m_vec = n_vec_m; m_pend = n_pend; m_prev = n_prev;
        #1;
    endtask

    task automatic do_return();
        bus.return_req = 1'b1;
        cycle();
        bus.return_req = 1'b0;
        repeat (RD) cycle();
    endtask

    initial begin
        n_vec = 0; n_err = 0; clock = 1'b0; reset = 1'b1; m_valid = 1'b0;
        m_mode = 0; m_cnt = 0; m_isr = 1'b0; m_line = 0; m_vec = 14'h0;
        m_pend = 4'h0; m_prev = 4'h0;
        bus.return_req = 1'b0; bus.halt = 1'b0; bus.fetch_stl_req = 1'b0;
        bus.dec_stl_req = 1'b0; bus.irq = 4'h0; bus.irq_enable = 1'b0;
        bus.irq_vector_table = {14'h1FFF, 14'h0456, 14'h0123, 14'h0ABC};
        #1;
        repeat (2) cycle();
        reset = 1'b0;
        chk("reset_state", 64'(bus.control_state), 64'd0);

        // Two lines rise together: line 1 wins, line 2 waits for the return
        bus.irq_enable = 1'b1; bus.irq = 4'b0110;
        cycle(); cycle();
        chk("int_state", 64'(bus.control_state), 64'd2);
        chk("int_word", 64'(bus.new_inst_word), 64'h048C0042);
        chk("int_ack", 64'(bus.irq_ack), 64'b0010);
        cycle(); cycle();
        chk("isr_blocks", 64'(bus.control_state), 64'd0);
        chk("isr_set", 64'(bus.in_isr), 64'd1);

        bus.return_req = 1'b1; cycle(); bus.return_req = 1'b0;
        chk("ret_cs0", 64'(bus.control_state), 64'd5);
        cycle();
        chk("ret_cs1", 64'(bus.control_state), 64'd5);
        cycle();
        chk("ret_cs2", 64'(bus.control_state), 64'd7);
        chk("ret_sel", 64'(bus.prog_cntr_load_sel), 64'b100);
        cycle();
        chk("ret_done", 64'(bus.in_isr), 64'd0);
        cycle();
        chk("deferred_ack", 64'(bus.irq_ack), 64'b0100);
        cycle(); bus.irq = 4'h0;
        do_return();

        // Halt with interrupts masked, then unmask
        bus.irq_enable = 1'b0; bus.halt = 1'b1; cycle(); bus.halt = 1'b0;
        bus.irq = 4'b0001; cycle(); cycle();
        bus.return_req = 1'b1; cycle(); bus.return_req = 1'b0;
        chk("halt_hold", 64'(bus.control_state), 64'd1);
        bus.irq_enable = 1'b1; cycle();
        chk("halt_int", 64'(bus.new_inst_word), 64'h2AF00042);
        cycle();
        chk("halt_exit", 64'(bus.control_state), 64'd0);
        bus.irq = 4'h0; do_return();

        // Held decode stall with an interrupt edge inside it
        bus.dec_stl_req = 1'b1; cycle();
        chk("stld_cs", 64'(bus.control_state), 64'd4);
        bus.irq = 4'b1000; cycle(); cycle();
        chk("stld_both", 64'({bus.stall_fetch, bus.stall_decode}), 64'b11);
        bus.dec_stl_req = 1'b0; cycle();
        chk("stld_int", 64'(bus.prog_cntr_int_addr), 64'h1FFF);
        cycle(); bus.irq = 4'h0; do_return();
        bus.return_req = 1'b1; bus.halt = 1'b1; bus.fetch_stl_req = 1'b1; bus.dec_stl_req = 1'b1;
        cycle();
        bus.return_req = 1'b0; bus.halt = 1'b0; bus.fetch_stl_req = 1'b0; bus.dec_stl_req = 1'b0;
        chk("ret_priority", 64'(bus.control_state), 64'd5);
        repeat (RD - 1) cycle();

        // Reset in the middle of a return drain with a fresh pending bit
        bus.irq = 4'b0100; cycle(); cycle(); cycle(); bus.irq = 4'h0;
        bus.return_req = 1'b1; cycle(); bus.return_req = 1'b0;
        bus.irq = 4'b1000; cycle(); bus.irq = 4'h0;
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("rst_mid_cs", 64'(bus.control_state), 64'd0);
        chk("rst_mid_isr", 64'(bus.in_isr), 64'd0);
        cycle(); cycle();
        chk("rst_pend_clr", 64'(bus.control_state), 64'd0);

        // New edge on line 0 in the same cycle as its acknowledge
        bus.irq = 4'b0001; cycle(); bus.irq = 4'h0; cycle();
        chk("ack0", 64'(bus.irq_ack), 64'b0001);
        bus.irq = 4'b0001; cycle();
        do_return(); cycle();
        chk("reack0", 64'(bus.irq_ack), 64'b0001);
        cycle(); do_return();

        for (int k = 0; k < 400; k++) begin
            reset = ($urandom_range(63) == 0);
            bus.return_req = ($urandom_range(7) == 0);
            bus.halt = ($urandom_range(9) == 0);
            bus.fetch_stl_req = ($urandom_range(3) == 0);
            bus.dec_stl_req = ($urandom_range(3) == 0);
            if ($urandom_range(2) == 0) bus.irq = 4'($urandom);
            bus.irq_enable = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) bus.irq_vector_table = 56'({$urandom, $urandom});
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
